// File: rtl/hello_scroll_ctrl.sv
// Scrolls "HELLO" plus blank padding across NUM_DIGITS active-low 7-segment digits.
// Optional HELLO_SCROLL_BLINK_EN: while paused, the frozen frame blinks at the scroll tick rate.
module hello_scroll_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 8
) (
    input  logic                    CLOCK_50,
    input  logic [0:0]              KEY,
    input  logic [1:0]              SW,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(MSG_LEN);
    localparam int IW  = PW + 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(MSG_LEN - 1);
    localparam logic [IW-1:0] LEN_IDX  = IW'(MSG_LEN);

    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           cnt_r;
    logic [PW-1:0]           pos_r;
    logic                    blink_r;
    logic [1:0]              sw_meta_r;
    logic [1:0]              sw_sync_r;

    logic                    run_s;
    logic                    dir_s;
    logic                    tick_s;
    logic [CW-1:0]           cnt_next_s;
    logic [PW-1:0]           pos_step_s;
    logic [7*NUM_DIGITS-1:0] frame_s;

    function automatic logic [6:0] msg_char(input logic [IW-1:0] idx);
        case (idx)
            IW'(0):  msg_char = SEG_H;
            IW'(1):  msg_char = SEG_E;
            IW'(2):  msg_char = SEG_L;
            IW'(3):  msg_char = SEG_L;
            IW'(4):  msg_char = SEG_O;
            default: msg_char = SEG_BLANK;
        endcase
    endfunction

    // The offset is reduced at elaboration, so the sum stays below 2*MSG_LEN.
    function automatic logic [IW-1:0] wrap_idx(input logic [PW-1:0] pos, input int off);
        logic [IW-1:0] sum;
        sum = {1'b0, pos} + IW'(off % MSG_LEN);
        if (sum >= LEN_IDX) begin
            wrap_idx = sum - LEN_IDX;
        end else begin
            wrap_idx = sum;
        end
    endfunction

    assign run_s  = sw_sync_r[0];
    assign dir_s  = sw_sync_r[1];
    assign tick_s = (cnt_r == CNT_MAX);

    // Next prescaler count and next scroll position for the selected direction.
    always_comb begin
        cnt_next_s = '0;
        pos_step_s = pos_r;
        if (tick_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
        if (dir_s) begin
            if (pos_r == PW'(0)) begin
                pos_step_s = POS_MAX;
            end else begin
                pos_step_s = pos_r - PW'(1);
            end
        end else begin
            if (pos_r == POS_MAX) begin
                pos_step_s = PW'(0);
            end else begin
                pos_step_s = pos_r + PW'(1);
            end
        end
    end

    // Frame that hex_out will latch on the next edge.
    always_comb begin
        frame_s = {(7*NUM_DIGITS){1'b1}};
        if ((state_r == S_RUN || state_r == S_HOLD) && !blink_r) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                frame_s[7*k +: 7] = msg_char(wrap_idx(pos_r, NUM_DIGITS - 1 - k));
            end
        end else begin
            frame_s = {(7*NUM_DIGITS){1'b1}};
        end
    end

    // Switch synchroniser, prescaler, scroll FSM and registered display bus.
    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            state_r   <= S_BLANK;
            cnt_r     <= '0;
            pos_r     <= '0;
            blink_r   <= 1'b0;
            sw_meta_r <= 2'b00;
            sw_sync_r <= 2'b00;
            hex_out   <= {(7*NUM_DIGITS){1'b1}};
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
            hex_out   <= frame_s;
            case (state_r)
                S_BLANK: begin
                    cnt_r   <= cnt_next_s;
                    blink_r <= 1'b0;
                    if (tick_s) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_BLANK;
                    end
                end
                S_RUN: begin
                    cnt_r   <= cnt_next_s;
                    blink_r <= 1'b0;
                    if (!run_s) begin
                        state_r <= S_HOLD;
                    end else if (tick_s) begin
                        pos_r <= pos_step_s;
                    end else begin
                        pos_r <= pos_r;
                    end
                end
                S_HOLD: begin
`ifdef HELLO_SCROLL_BLINK_EN
                    cnt_r <= cnt_next_s;
                    if (run_s) begin
                        state_r <= S_RUN;
                        blink_r <= 1'b0;
                    end else if (tick_s) begin
                        blink_r <= ~blink_r;
                    end else begin
                        blink_r <= blink_r;
                    end
`else
                    blink_r <= 1'b0;
                    if (run_s) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_HOLD;
                    end
`endif
                end
                default: begin
                    state_r <= S_BLANK;
                    cnt_r   <= '0;
                    pos_r   <= '0;
                    blink_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed, table-driven bench for hello_scroll_ctrl with DIV=8, four digits, eight-character message.
module tb_hello_scroll_ctrl;

    localparam logic [6:0] H = 7'h09;
    localparam logic [6:0] E = 7'h06;
    localparam logic [6:0] L = 7'h47;
    localparam logic [6:0] O = 7'h40;
    localparam logic [6:0] B = 7'h7F;
    localparam logic [27:0] BLANK = 28'hFFFFFFF;

    typedef struct {
        logic [1:0]  sw;
        int          edges;
        logic [27:0] exp;
        int          exp_cnt;
    } vec_t;

    logic        clk;
    logic [0:0]  key;
    logic [1:0]  sw;
    logic [27:0] hex;

    int checks;
    int errors;
    logic [27:0] pf [8];
    vec_t vecs [24];

    hello_scroll_ctrl #(
        .CLK_HZ(8), .TICK_HZ(1), .NUM_DIGITS(4), .MSG_LEN(8)
    ) dut (
        .CLOCK_50(clk),
        .KEY(key),
        .SW(sw),
        .hex_out(hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] fr(input logic [6:0] a, input logic [6:0] b,
                                       input logic [6:0] c, input logic [6:0] d);
        return {a, b, c, d};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pf[0] = fr(H, E, L, L);
        pf[1] = fr(E, L, L, O);
        pf[2] = fr(L, L, O, B);
        pf[3] = fr(L, O, B, B);
        pf[4] = fr(O, B, B, B);
        pf[5] = fr(B, B, B, H);
        pf[6] = fr(B, B, H, E);
        pf[7] = fr(B, H, E, L);

        // Edge numbers are counted from reset release; exp_cnt < 0 skips the counter check.
        vecs[0]  = '{2'b01, 8,  BLANK, 0};   // E8: first tick edge, still blank
        vecs[1]  = '{2'b01, 1,  pf[0], -1};  // E9: HELL
        vecs[2]  = '{2'b01, 7,  pf[0], -1};  // E16: pos->1, display lags
        vecs[3]  = '{2'b01, 1,  pf[1], -1};  // E17
        vecs[4]  = '{2'b01, 8,  pf[2], -1};
        vecs[5]  = '{2'b01, 8,  pf[3], -1};
        vecs[6]  = '{2'b01, 8,  pf[4], -1};
        vecs[7]  = '{2'b01, 8,  pf[5], -1};
        vecs[8]  = '{2'b01, 8,  pf[6], -1};
        vecs[9]  = '{2'b01, 8,  pf[7], -1};  // E65
        vecs[10] = '{2'b01, 7,  pf[7], -1};  // E72: pos 7->0
        vecs[11] = '{2'b01, 1,  pf[0], -1};  // E73: wrapped
        vecs[12] = '{2'b11, 7,  pf[0], -1};  // E80: first right step
        vecs[13] = '{2'b11, 1,  pf[7], -1};  // E81
        vecs[14] = '{2'b11, 8,  pf[6], -1};  // E89
        vecs[15] = '{2'b01, 8,  pf[7], -1};  // E97: left again
        vecs[16] = '{2'b01, 8,  pf[0], -1};
        vecs[17] = '{2'b01, 8,  pf[1], -1};  // E113
        vecs[18] = '{2'b01, 7,  pf[1], -1};  // E120: pos->2, cnt 0
        vecs[19] = '{2'b00, 1,  pf[2], -1};  // pause seen after E122, hold from E123 with cnt 3
        vecs[20] = '{2'b00, 49, pf[2], 3};   // E170: frame and cnt frozen
        vecs[21] = '{2'b01, 8,  pf[2], -1};  // E178: resume at E173, advance 5 cycles later
        vecs[22] = '{2'b01, 1,  pf[3], 1};   // E179
        vecs[23] = '{2'b01, 8,  pf[4], -1};  // E187: pos 4

        key = 1'b0;
        sw  = 2'b01;
        #22;
        check("reset_hex", hex, BLANK);
        check("reset_pos", 28'(dut.pos_r), 28'h0);
        check("reset_cnt", 28'(dut.cnt_r), 28'h0);
        key = 1'b1;

        for (int i = 0; i < 24; i++) begin
            sw = vecs[i].sw;
            wait_edges(vecs[i].edges);
            check($sformatf("vec%0d_hex", i), hex, vecs[i].exp);
            if (vecs[i].exp_cnt >= 0) begin
                check($sformatf("vec%0d_cnt", i), 28'(dut.cnt_r), 28'(vecs[i].exp_cnt));
            end
        end

        // Asynchronous reset in the middle of a frame at pos 4.
        #2 key = 1'b0;
        #1;
        check("midreset_hex", hex, BLANK);
        check("midreset_pos", 28'(dut.pos_r), 28'h0);
        #1 key = 1'b1;
        wait_edges(8);
        check("restart_blank", hex, BLANK);
        wait_edges(1);
        check("restart_hell", hex, pf[0]);

`ifdef HELLO_SCROLL_BLINK_EN
        begin
            int changes;
            logic [27:0] prev;
            sw = 2'b00;
            wait_edges(3);
            prev = hex;
            changes = 0;
            for (int i = 0; i < 48; i++) begin
                wait_edges(1);
                if (hex !== BLANK) begin
                    check($sformatf("blink_frame%0d", i), hex, pf[0]);
                end
                if (hex !== prev) begin
                    changes++;
                end
                prev = hex;
            end
            check("blink_toggles", 28'(changes >= 5), 28'h1);
            sw = 2'b01;
            wait_edges(4);
            for (int i = 0; i < 16; i++) begin
                wait_edges(1);
                check($sformatf("resume_steady%0d", i), 28'(hex == BLANK), 28'h0);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
